// File: rtl/segment_swapchain.sv
// segment_swapchain
//   Segment swap controller for the modulation/STM playback path. It selects
//   which of NUM_SEGMENT buffer segments drives the output and when a newly
//   requested segment takes over. It counts finite repetitions and raises
//   STOP after the last one.
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   SYS_TIME          64-bit system time used by the SYS_TIME transition mode
//   UPDATE_SETTINGS   one-cycle strobe that latches REQ_SEGMENT/TRANSITION_*
//   REQ_SEGMENT       requested segment
//   TRANSITION_MODE   00 SYNC_IDX, 01 SYS_TIME, 02 GPIO, F0 EXT, FF IMMEDIATE
//   TRANSITION_VALUE  transition time, or GPIO number in the low bits
//   CYCLE/REP/SYNC_IDX  per-segment last index, repeat count, sync index
//   GPIO_IN           synchronised external triggers
//   SEGMENT, STOP     active segment, finite playback complete
//   IDX               per-segment index (registered sync index or local tic)
//   LOOP_DONE         one-cycle pulse per completed finite loop
//   WAITING           high while waiting for a transition trigger
module segment_swapchain #(
  parameter int NUM_SEGMENT = 2,
  parameter int IDX_WIDTH   = 15,
  parameter int REP_WIDTH   = 16,
  parameter int NUM_GPIO    = 4,
  localparam int SEG_W      = $clog2(NUM_SEGMENT),
  localparam int GPIO_W     = $clog2(NUM_GPIO)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [63:0]          SYS_TIME,
  input  logic                 UPDATE_SETTINGS,
  input  logic [SEG_W-1:0]     REQ_SEGMENT,
  input  logic [7:0]           TRANSITION_MODE,
  input  logic [63:0]          TRANSITION_VALUE,
  input  logic [IDX_WIDTH-1:0] CYCLE    [NUM_SEGMENT],
  input  logic [REP_WIDTH-1:0] REP      [NUM_SEGMENT],
  input  logic [IDX_WIDTH-1:0] SYNC_IDX [NUM_SEGMENT],
  input  logic [NUM_GPIO-1:0]  GPIO_IN,
  output logic [SEG_W-1:0]     SEGMENT,
  output logic                 STOP,
  output logic [IDX_WIDTH-1:0] IDX      [NUM_SEGMENT],
  output logic                 LOOP_DONE,
  output logic                 WAITING
);

  typedef enum logic [1:0] {ST_INFINITE, ST_WAIT, ST_FINITE} state_t;
  typedef enum logic [7:0] {
    MODE_SYNC_IDX  = 8'h00,
    MODE_SYS_TIME  = 8'h01,
    MODE_GPIO      = 8'h02,
    MODE_EXT       = 8'hF0,
    MODE_IMMEDIATE = 8'hFF
  } mode_t;
  typedef enum logic {IDX_SYNC, IDX_TIC} idx_mode_t;

  state_t               state_q, state_d;
  idx_mode_t            idx_mode_q, idx_mode_d;
  logic [SEG_W-1:0]     seg_q, seg_d;
  logic [SEG_W-1:0]     req_seg_q, req_seg_d;
  logic                 stop_q, stop_d;
  logic                 loop_done_q, loop_done_d;
  logic                 ext_mode_q, ext_mode_d;
  logic                 ge_q, ge_d;
  logic                 wait_first_q, wait_first_d;
  logic [7:0]           mode_q, mode_d;
  logic [63:0]          t_trans_q, t_trans_d;
  logic [GPIO_W-1:0]    gpio_sel_q, gpio_sel_d;
  logic [REP_WIDTH-1:0] rep_q, rep_d;
  logic [REP_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
  logic [IDX_WIDTH-1:0] idx_old_q [NUM_SEGMENT];
  logic [IDX_WIDTH-1:0] idx_old_d [NUM_SEGMENT];
  logic [IDX_WIDTH-1:0] tic_idx_q [NUM_SEGMENT];
  logic [IDX_WIDTH-1:0] tic_idx_d [NUM_SEGMENT];

  logic [NUM_SEGMENT-1:0] chg, wrap;
  logic                   complete, start, tic_start;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SEGMENT; i++) begin
      chg[i]  = idx_old_q[i] != SYNC_IDX[i];
      wrap[i] = chg[i] && (SYNC_IDX[i] == '0);
      IDX[i]  = (idx_mode_q == IDX_TIC) ? tic_idx_q[i] : idx_old_q[i];
    end
  end

  assign idx_old_d = SYNC_IDX;
  assign ge_d      = SYS_TIME >= t_trans_q;

  always_comb begin
    state_d      = state_q;
    idx_mode_d   = idx_mode_q;
    seg_d        = seg_q;
    req_seg_d    = req_seg_q;
    stop_d       = stop_q;
    loop_done_d  = 1'b0;
    ext_mode_d   = ext_mode_q;
    wait_first_d = 1'b0;
    mode_d       = mode_q;
    t_trans_d    = t_trans_q;
    gpio_sel_d   = gpio_sel_q;
    rep_d        = rep_q;
    loop_cnt_d   = loop_cnt_q;
    tic_idx_d    = tic_idx_q;
    complete     = 1'b0;
    start        = 1'b0;
    tic_start    = 1'b0;

    if (UPDATE_SETTINGS) begin
      // rep is latched in both branches: an immediate finite swap still
      // needs it for the loop count compare.
      rep_d = REP[REQ_SEGMENT];
      if ((REP[REQ_SEGMENT] == '1) || (TRANSITION_MODE == MODE_IMMEDIATE)) begin
        seg_d      = REQ_SEGMENT;
        stop_d     = 1'b0;
        idx_mode_d = IDX_SYNC;
        ext_mode_d = (TRANSITION_MODE == MODE_EXT);
        loop_cnt_d = '0;
        state_d    = (REP[REQ_SEGMENT] == '1) ? ST_INFINITE : ST_FINITE;
      end else begin
        req_seg_d    = REQ_SEGMENT;
        mode_d       = TRANSITION_MODE;
        t_trans_d    = TRANSITION_VALUE;
        gpio_sel_d   = TRANSITION_VALUE[GPIO_W-1:0];
        wait_first_d = 1'b1;
        state_d      = ST_WAIT;
      end
    end else begin
      case (state_q)
        ST_INFINITE: begin
          if (ext_mode_q && wrap[seg_q])
            seg_d = (seg_q == SEG_W'(NUM_SEGMENT - 1)) ? '0 : seg_q + 1'b1;
        end
        ST_WAIT: begin
          case (mode_q)
            MODE_SYNC_IDX: start = wrap[req_seg_q];
            // ge_q on the first cycle still reflects the previous t_trans.
            MODE_SYS_TIME: begin
              start     = ge_q && !wait_first_q;
              tic_start = 1'b1;
            end
            MODE_GPIO: begin
              start     = chg[req_seg_q] && GPIO_IN[gpio_sel_q];
              tic_start = 1'b1;
            end
            default: start = 1'b0;
          endcase
          if (start) begin
            stop_d     = 1'b0;
            loop_cnt_d = '0;
            seg_d      = req_seg_q;
            state_d    = ST_FINITE;
            idx_mode_d = tic_start ? IDX_TIC : IDX_SYNC;
            if (tic_start) tic_idx_d[req_seg_q] = '0;
          end
        end
        ST_FINITE: begin
          if (idx_mode_q == IDX_SYNC) begin
            complete = wrap[seg_q];
          end else if (chg[seg_q]) begin
            if (tic_idx_q[seg_q] == CYCLE[seg_q]) begin
              tic_idx_d[seg_q] = '0;
              complete         = 1'b1;
            end else begin
              tic_idx_d[seg_q] = tic_idx_q[seg_q] + 1'b1;
            end
          end
          if (complete && !stop_q) begin
            loop_done_d = 1'b1;
            if (loop_cnt_q == rep_q) stop_d = 1'b1;
            else                     loop_cnt_d = loop_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_INFINITE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_INFINITE;
      idx_mode_q   <= IDX_SYNC;
      seg_q        <= '0;
      req_seg_q    <= '0;
      stop_q       <= 1'b0;
      loop_done_q  <= 1'b0;
      ext_mode_q   <= 1'b0;
      ge_q         <= 1'b0;
      wait_first_q <= 1'b0;
      mode_q       <= '0;
      t_trans_q    <= '0;
      gpio_sel_q   <= '0;
      rep_q        <= '0;
      loop_cnt_q   <= '0;
      idx_old_q    <= '{default: '0};
      tic_idx_q    <= '{default: '0};
    end else begin
      state_q      <= state_d;
      idx_mode_q   <= idx_mode_d;
      seg_q        <= seg_d;
      req_seg_q    <= req_seg_d;
      stop_q       <= stop_d;
      loop_done_q  <= loop_done_d;
      ext_mode_q   <= ext_mode_d;
      ge_q         <= ge_d;
      wait_first_q <= wait_first_d;
      mode_q       <= mode_d;
      t_trans_q    <= t_trans_d;
      gpio_sel_q   <= gpio_sel_d;
      rep_q        <= rep_d;
      loop_cnt_q   <= loop_cnt_d;
      idx_old_q    <= idx_old_d;
      tic_idx_q    <= tic_idx_d;
    end
  end

  assign SEGMENT   = seg_q;
  assign STOP      = stop_q;
  assign LOOP_DONE = loop_done_q;
  assign WAITING   = (state_q == ST_WAIT);

endmodule

// File: tb/tb_segment_swapchain.sv
// Testbench for segment_swapchain: a 4-segment instance exercises the update
// table, SYNC_IDX/SYS_TIME/GPIO transitions and resets; a 3-segment instance
// exercises EXT round-robin rotation across a non power-of-two wrap.
module tb_segment_swapchain;
  localparam int NS = 4;
  localparam int IW = 15;
  localparam int RW = 16;
  localparam int NG = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   sys_time, tval;
  logic          upd;
  logic [1:0]    req;
  logic [7:0]    mode;
  logic [IW-1:0] cyc  [NS];
  logic [RW-1:0] rep  [NS];
  logic [IW-1:0] sidx [NS];
  logic [NG-1:0] gpio;
  logic [1:0]    seg;
  logic          stop, ld, waiting;
  logic [IW-1:0] idx  [NS];

  logic          upd3;
  logic [1:0]    req3;
  logic [7:0]    mode3;
  logic [IW-1:0] cyc3  [3];
  logic [RW-1:0] rep3  [3];
  logic [IW-1:0] sidx3 [3];
  logic [1:0]    seg3;
  logic          stop3, ld3, wait3;
  logic [IW-1:0] idx3  [3];

  int checks = 0;
  int errors = 0;
  int np;
  logic [IW-1:0] prev;

  always #5 clk = ~clk;

  segment_swapchain #(.NUM_SEGMENT(NS), .IDX_WIDTH(IW), .REP_WIDTH(RW), .NUM_GPIO(NG)) u_dut (
    .CLK(clk), .RST(rst), .SYS_TIME(sys_time), .UPDATE_SETTINGS(upd),
    .REQ_SEGMENT(req), .TRANSITION_MODE(mode), .TRANSITION_VALUE(tval),
    .CYCLE(cyc), .REP(rep), .SYNC_IDX(sidx), .GPIO_IN(gpio),
    .SEGMENT(seg), .STOP(stop), .IDX(idx), .LOOP_DONE(ld), .WAITING(waiting)
  );

  segment_swapchain #(.NUM_SEGMENT(3), .IDX_WIDTH(IW), .REP_WIDTH(RW), .NUM_GPIO(NG)) u_dut3 (
    .CLK(clk), .RST(rst), .SYS_TIME(sys_time), .UPDATE_SETTINGS(upd3),
    .REQ_SEGMENT(req3), .TRANSITION_MODE(mode3), .TRANSITION_VALUE(tval),
    .CYCLE(cyc3), .REP(rep3), .SYNC_IDX(sidx3), .GPIO_IN(gpio),
    .SEGMENT(seg3), .STOP(stop3), .IDX(idx3), .LOOP_DONE(ld3), .WAITING(wait3)
  );

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  mode;
    logic [15:0] rep;
    logic [1:0]  seg;
    logic        stop;
    logic        wt;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_step(input int s);
    sidx[s] = (sidx[s] == cyc[s]) ? '0 : sidx[s] + 1'b1;
    tick();
  endtask

  task automatic wrap3(input int s);
    sidx3[s] = 15'd1;
    tick();
    sidx3[s] = '0;
    tick();
  endtask

  task automatic strobe(input logic [1:0] r, input logic [7:0] m, input logic [15:0] rp);
    req    = r;
    mode   = m;
    rep[r] = rp;
    upd    = 1'b1;
    tick();
    upd    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; upd = 1'b0; req = '0; mode = '0; tval = '0; sys_time = '0; gpio = '0;
    upd3 = 1'b0; req3 = '0; mode3 = '0;
    for (int i = 0; i < NS; i++) begin cyc[i] = 15'd9; rep[i] = '1; sidx[i] = '0; end
    for (int i = 0; i < 3; i++)  begin cyc3[i] = 15'd1; rep3[i] = '1; sidx3[i] = '0; end

    // update table: {req, mode, rep} -> {SEGMENT, STOP, WAITING} one cycle later
    vecs[0] = '{2'd1, 8'h00, 16'hFFFF, 2'd1, 1'b0, 1'b0};
    vecs[1] = '{2'd3, 8'hFF, 16'd5,    2'd3, 1'b0, 1'b0};
    vecs[2] = '{2'd2, 8'h02, 16'hFFFF, 2'd2, 1'b0, 1'b0};
    vecs[3] = '{2'd0, 8'h00, 16'd3,    2'd2, 1'b0, 1'b1};
    vecs[4] = '{2'd1, 8'h55, 16'd3,    2'd2, 1'b0, 1'b1};
    vecs[5] = '{2'd0, 8'hFF, 16'd0,    2'd0, 1'b0, 1'b0};
    vecs[6] = '{2'd3, 8'hF0, 16'hFFFF, 2'd3, 1'b0, 1'b0};

    #12;
    chk("rst_seg", 64'(seg), 64'd0);
    chk("rst_stop", 64'(stop), 64'd0);
    chk("rst_loop_done", 64'(ld), 64'd0);
    chk("rst_waiting", 64'(waiting), 64'd0);
    chk("rst_idx0", 64'(idx[0]), 64'd0);
    chk("rst_seg3", 64'(seg3), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      strobe(vecs[i].req, vecs[i].mode, vecs[i].rep);
      chk($sformatf("vec%0d_seg", i), 64'(seg), 64'(vecs[i].seg));
      chk($sformatf("vec%0d_stop", i), 64'(stop), 64'(vecs[i].stop));
      chk($sformatf("vec%0d_waiting", i), 64'(waiting), 64'(vecs[i].wt));
    end

    // SYNC_IDX transition to segment 2, rep=1 -> two loops
    strobe(2'd2, 8'h00, 16'd1);
    chk("sync_wait", 64'(waiting), 64'd1);
    for (int k = 1; k <= 9; k++) begin
      if (k == 5) begin
        prev    = sidx[2];
        sidx[2] = prev + 1'b1;
        #1;
        chk("idx_lag_before_edge", 64'(idx[2]), 64'(prev));
        tick();
        chk("idx_lag_after_edge", 64'(idx[2]), 64'(prev) + 64'd1);
      end else begin
        sync_step(2);
      end
    end
    chk("sync_still_wait", 64'(waiting), 64'd1);
    chk("sync_seg_held", 64'(seg), 64'd3);
    sync_step(2);
    chk("sync_swap_seg", 64'(seg), 64'd2);
    chk("sync_swap_waiting", 64'(waiting), 64'd0);
    chk("sync_swap_ld", 64'(ld), 64'd0);
    for (int w = 0; w < 3; w++) begin
      np = 0;
      for (int k = 0; k < 10; k++) begin
        sync_step(2);
        np += int'(ld);
      end
      chk($sformatf("sync_win%0d_pulses", w), 64'(np), (w < 2) ? 64'd1 : 64'd0);
      chk($sformatf("sync_win%0d_ld", w), 64'(ld), (w < 2) ? 64'd1 : 64'd0);
      chk($sformatf("sync_win%0d_stop", w), 64'(stop), (w >= 1) ? 64'd1 : 64'd0);
    end

    // SYS_TIME transition at 1000, TIC indexing with CYCLE[1]=3, rep=0
    cyc[1]   = 15'd3;
    sys_time = 64'd990;
    tval     = 64'd1000;
    strobe(2'd1, 8'h01, 16'd0);
    chk("st_wait", 64'(waiting), 64'd1);
    np = 0;
    for (int t = 991; t <= 1000; t++) begin
      sys_time = 64'(t);
      tick();
      if (seg != 2'd2) np++;
    end
    chk("st_no_early_swap", 64'(np), 64'd0);
    sys_time = 64'd1001;
    tick();
    chk("st_swap_seg", 64'(seg), 64'd1);
    chk("st_swap_stop", 64'(stop), 64'd0);
    chk("st_tic_start", 64'(idx[1]), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      sync_step(1);
      chk($sformatf("st_tic%0d", k), 64'(idx[1]), 64'(k % 4));
      if (k == 3) chk("st_stop_before_last", 64'(stop), 64'd0);
      if (k == 4) begin
        chk("st_loop_done", 64'(ld), 64'd1);
        chk("st_stop", 64'(stop), 64'd1);
      end
    end

    // SYS_TIME already in the past: swap 3 cycles after the strobe
    tval = 64'd5;
    strobe(2'd3, 8'h01, 16'd2);
    chk("past_c1_waiting", 64'(waiting), 64'd1);
    chk("past_c1_stop_held", 64'(stop), 64'd1);
    tick();
    chk("past_c2_seg", 64'(seg), 64'd1);
    tick();
    chk("past_c3_seg", 64'(seg), 64'd3);
    chk("past_c3_stop", 64'(stop), 64'd0);

    // GPIO transition on GPIO_IN[3]
    cyc[0] = 15'd7;
    tval   = 64'd3;
    strobe(2'd0, 8'h02, 16'd4);
    gpio = 4'b0100;
    sync_step(0);
    chk("gpio_wrong_pin", 64'(waiting), 64'd1);
    gpio = 4'b1000;
    tick();
    chk("gpio_no_chg", 64'(waiting), 64'd1);
    sync_step(0);
    chk("gpio_swap_seg", 64'(seg), 64'd0);
    chk("gpio_swap_waiting", 64'(waiting), 64'd0);
    chk("gpio_tic_start", 64'(idx[0]), 64'd0);
    gpio = '0;
    sync_step(0);
    chk("gpio_tic_inc", 64'(idx[0]), 64'd1);

    // asynchronous reset while waiting
    strobe(2'd2, 8'hFF, 16'hFFFF);
    strobe(2'd1, 8'h00, 16'd2);
    chk("rw_pre_waiting", 64'(waiting), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rw_seg", 64'(seg), 64'd0);
    chk("rw_waiting", 64'(waiting), 64'd0);
    chk("rw_idx0", 64'(idx[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // asynchronous reset in FINITE_LOOP with STOP high
    strobe(2'd2, 8'hFF, 16'd0);
    for (int k = 0; k < 10; k++) sync_step(2);
    chk("rf_pre_stop", 64'(stop), 64'd1);
    chk("rf_pre_ld", 64'(ld), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rf_seg", 64'(seg), 64'd0);
    chk("rf_stop", 64'(stop), 64'd0);
    chk("rf_ld", 64'(ld), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // strobe coincident with a wrap of the pending segment is a new request
    strobe(2'd2, 8'h00, 16'd1);
    sidx[2] = 15'd9;
    tick();
    sidx[2] = '0;
    strobe(2'd1, 8'h00, 16'd1);
    chk("coinc_waiting", 64'(waiting), 64'd1);
    chk("coinc_seg", 64'(seg), 64'd0);
    sidx[1] = 15'd5;
    tick();
    chk("coinc_chg_no_wrap", 64'(waiting), 64'd1);
    sidx[1] = '0;
    tick();
    chk("coinc_new_req_seg", 64'(seg), 64'd1);

    // EXT round-robin on the 3-segment instance
    req3 = 2'd0; mode3 = 8'hF0; upd3 = 1'b1;
    tick();
    upd3 = 1'b0;
    wrap3(0);
    chk("ext_0to1", 64'(seg3), 64'd1);
    wrap3(0);
    chk("ext_inactive_wrap", 64'(seg3), 64'd1);
    wrap3(1);
    chk("ext_1to2", 64'(seg3), 64'd2);
    wrap3(2);
    chk("ext_2to0", 64'(seg3), 64'd0);
    chk("ext_stop", 64'(stop3), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
